mtr_duty_slew: RTL and testbench

Converts a signed motor-speed command from the balance controller into the 11-bit unsigned `duty` and the H-bridge direction lines consumed by the 11-bit PWM generator. It sits directly upstream of the PWM stage, one instance per motor. It runs an 11-bit period counter that is reset-aligned with the PWM counter, so `duty` changes only at PWM period boundaries. It also applies a per-period slew limit, and it inserts dead periods whenever the direction changes.

---
 rtl/mtr_duty_slew_pkg.sv | 35 +++
 rtl/mtr_duty_slew_if.sv | 27 ++
 rtl/mtr_duty_slew_prd_cntr.sv | 28 ++
 rtl/mtr_duty_slew.sv | 156 +++++++++++++++
 tb/tb_mtr_duty_slew.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mtr_duty_slew_pkg.sv
// mtr_pkg
//   Shared definitions for the motor duty path. The PWM stage and the
//   duty slew block both take the period width from here so their
//   counters can never disagree on the period length.
//   Contents: PRD_W, DUTY_MAX, mtr_state_t, slewToward().
package mtr_pkg;

  localparam int PRD_W = 11;
  localparam logic [PRD_W-1:0] DUTY_MAX = 11'd2047;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} mtr_state_t;

  // Moves cur toward tgt by at most step counts and lands exactly on tgt.
  // The sums carry one extra bit, so an up step past 2047 is clamped
  // instead of wrapping. A down step only subtracts when the result stays
  // at or above tgt, so it can never underflow.
  function automatic logic [PRD_W-1:0] slewToward(
    input logic [PRD_W-1:0] cur,
    input logic [PRD_W-1:0] tgt,
    input logic [PRD_W:0]   step
  );
    logic [PRD_W:0] upSum;
    logic [PRD_W:0] dnLimit;
    upSum   = {1'b0, cur} + step;
    dnLimit = {1'b0, tgt} + step;
    if (cur < tgt) begin
      return (upSum > {1'b0, tgt}) ? tgt : upSum[PRD_W-1:0];
    end else if ({1'b0, cur} >= dnLimit) begin
      return cur - step[PRD_W-1:0];
    end else begin
      return tgt;
    end
  endfunction

endpackage

// File: rtl/mtr_duty_slew_if.sv
// mtr_duty_slew_if
//   Bundle between the balance controller / PWM stage and one
//   mtr_duty_slew instance.
//   master: drives spd, spd_vld, en; observes duty, fwd, rev, prd_tick.
//   slave : the duty slew block itself.
interface mtr_duty_slew_if;
  import mtr_pkg::*;

  logic [11:0]      spd;
  logic             spd_vld;
  logic             en;
  logic [PRD_W-1:0] duty;
  logic             fwd;
  logic             rev;
  logic             prd_tick;

  modport master (
    output spd, spd_vld, en,
    input  duty, fwd, rev, prd_tick
  );

  modport slave (
    input  spd, spd_vld, en,
    output duty, fwd, rev, prd_tick
  );

endinterface

// File: rtl/mtr_duty_slew_prd_cntr.sv
// prd_cntr
//   Free-running 11-bit PWM period counter. It is reset by the same rst_n
//   as the PWM generator, so both counters stay in lockstep.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   o_tick : high for the single cycle in which the count equals 2047
module prd_cntr
  import mtr_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  logic [PRD_W-1:0] r_cnt;

  // The count wraps 2047 -> 0 naturally through its 11-bit width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == DUTY_MAX);

endmodule

// File: rtl/mtr_duty_slew.sv
// mtr_duty_slew
//   Turns a signed speed command into an 11-bit duty plus H-bridge
//   direction enables. Duty changes only at PWM period boundaries and by
//   at most STEP counts per period. A reversal ramps duty down to 0 and
//   then holds both bridge sides off for DEAD_PRDS periods.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mtr_duty_slew_if (spd/spd_vld/en in,
//           duty/fwd/rev/prd_tick out)
module mtr_duty_slew #(
  parameter int unsigned STEP      = 64,
  parameter int unsigned DEAD_PRDS = 2
) (
  input logic              clk,
  input logic              rst_n,
  mtr_duty_slew_if.slave   bus
);
  import mtr_pkg::*;

  localparam logic [PRD_W:0] STEP_W = STEP[PRD_W:0];
  localparam logic [3:0]     DEAD_W = DEAD_PRDS[3:0];

  logic             w_prdTick;
  logic [11:0]      w_spdAbs;
  logic [PRD_W-1:0] w_spdMag;

  logic [PRD_W-1:0] r_tgtMag;
  logic             r_tgtDir;

  mtr_state_t       r_state;
  logic [PRD_W-1:0] r_duty;
  logic             r_curDir;
  logic [3:0]       r_deadCnt;
  logic             r_fwd;
  logic             r_rev;

  mtr_state_t       w_stateNxt;
  logic [PRD_W-1:0] w_dutyNxt;
  logic             w_curDirNxt;
  logic [3:0]       w_deadCntNxt;
  logic             w_fwdNxt;
  logic             w_revNxt;

  prd_cntr u_prdCntr (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_prdTick)
  );

  // Magnitude of the command. Only -2048 has no positive 12-bit twin;
  // its negation comes back with bit 11 set and is clamped to 2047.
  assign w_spdAbs = bus.spd[11] ? (~bus.spd + 12'd1) : bus.spd;
  assign w_spdMag = w_spdAbs[11] ? DUTY_MAX : w_spdAbs[PRD_W-1:0];

  // Target capture. A zero command means "stop" and keeps the last
  // direction, so it ramps down without triggering a reversal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tgtMag <= '0;
      r_tgtDir <= 1'b0;
    end else if (bus.spd_vld) begin
      if (bus.spd == 12'd0) begin
        r_tgtMag <= '0;
      end else begin
        r_tgtMag <= w_spdMag;
        r_tgtDir <= bus.spd[11];
      end
    end
  end

  // State register. The duty and the bridge enables are registered here,
  // so the PWM stage always sees clean, glitch-free values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_duty    <= '0;
      r_curDir  <= 1'b0;
      r_deadCnt <= '0;
      r_fwd     <= 1'b0;
      r_rev     <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_duty    <= w_dutyNxt;
      r_curDir  <= w_curDirNxt;
      r_deadCnt <= w_deadCntNxt;
      r_fwd     <= w_fwdNxt;
      r_rev     <= w_revNxt;
    end
  end

  // Next-state logic. Everything waits for the period tick except a drop
  // of en, which forces a stop on the very next edge.
  always_comb begin
    w_stateNxt   = r_state;
    w_dutyNxt    = r_duty;
    w_curDirNxt  = r_curDir;
    w_deadCntNxt = r_deadCnt;
    if (!bus.en) begin
      w_stateNxt = IDLE;
      w_dutyNxt  = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_dutyNxt = '0;
          if (w_prdTick) begin
            w_curDirNxt = r_tgtDir;
            w_stateNxt  = RUN;
          end
        end
        RUN: begin
          if (w_prdTick) begin
            if (r_tgtDir == r_curDir) begin
              w_dutyNxt = slewToward(r_duty, r_tgtMag, STEP_W);
            end else if (r_duty == '0) begin
              w_stateNxt   = DEAD;
              w_deadCntNxt = DEAD_W;
            end else begin
              w_dutyNxt = slewToward(r_duty, {PRD_W{1'b0}}, STEP_W);
            end
          end
        end
        DEAD: begin
          w_dutyNxt = '0;
          if (w_prdTick) begin
            w_deadCntNxt = r_deadCnt - 4'd1;
            if (r_deadCnt == 4'd1) begin
              w_curDirNxt = r_tgtDir;
              w_stateNxt  = RUN;
            end
          end
        end
        default: begin
          w_stateNxt = IDLE;
          w_dutyNxt  = '0;
        end
      endcase
    end
  end

  // Bridge enables are decoded from the upcoming state. Only RUN drives
  // one side, so fwd and rev are never high together.
  always_comb begin
    w_fwdNxt = 1'b0;
    w_revNxt = 1'b0;
    if (w_stateNxt == RUN) begin
      w_fwdNxt = ~w_curDirNxt;
      w_revNxt = w_curDirNxt;
    end
  end

  assign bus.duty     = r_duty;
  assign bus.fwd      = r_fwd;
  assign bus.rev      = r_rev;
  assign bus.prd_tick = w_prdTick;

endmodule

// File: tb/tb_mtr_duty_slew.sv
// tb_mtr_duty_slew
//   Directed bench for mtr_duty_slew. Instance dut uses the default
//   STEP/DEAD_PRDS. Instance dutBig uses a large STEP, so the 2047 clamp
//   is reached within a few periods.
module tb_mtr_duty_slew;
  import mtr_pkg::*;

  typedef struct {
    logic        strobe;
    logic [11:0] spd;
    int          expDuty;
    int          expFwd;
    int          expRev;
    int          expBigDuty;
    int          expBigRev;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[19];

  mtr_duty_slew_if mainBus();
  mtr_duty_slew_if bigBus();

  mtr_duty_slew dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mainBus)
  );

  mtr_duty_slew #(.STEP(1024), .DEAD_PRDS(1)) dutBig (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bigBus)
  );

  // 50 MHz system clock
  always #10 clk = ~clk;

  // One counted comparison, reported on mismatch
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Checks the three drive outputs of the main instance
  task automatic checkMain(input string tag, input int d, input int f, input int r);
    checkOutput({tag, "_duty"}, int'(mainBus.duty), d);
    checkOutput({tag, "_fwd"}, int'(mainBus.fwd), f);
    checkOutput({tag, "_rev"}, int'(mainBus.rev), r);
  endtask

  // Single-cycle spd_vld strobe on the main instance, issued mid-period
  task automatic applyStimulus(input logic [11:0] spdVal);
    mainBus.spd = spdVal;
    mainBus.spd_vld = 1'b1;
    @(posedge clk);
    #1;
    mainBus.spd_vld = 1'b0;
  endtask

  // Runs up to just after the next boundary edge, with a cycle budget
  task automatic waitBoundary(input string tag);
    int n;
    n = 0;
    while (n < 2100) begin
      @(negedge clk);
      if (mainBus.prd_tick) break;
      n++;
    end
    if (n >= 2100) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_boundary_timeout actual=%0d expected=<2100", tag, n);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Per boundary: optional strobe, then expected main and big outputs
    vecs[0]  = '{1'b1, 12'd192,       0,   1, 0, 0,    1};
    vecs[1]  = '{1'b0, 12'd0,         64,  1, 0, 1024, 1};
    vecs[2]  = '{1'b0, 12'd0,         128, 1, 0, 2047, 1};
    vecs[3]  = '{1'b0, 12'd0,         192, 1, 0, 2047, 1};
    vecs[4]  = '{1'b0, 12'd0,         192, 1, 0, 2047, 1};
    vecs[5]  = '{1'b1, 12'(-128),     128, 1, 0, 2047, 1};
    vecs[6]  = '{1'b0, 12'd0,         64,  1, 0, 2047, 1};
    vecs[7]  = '{1'b0, 12'd0,         0,   1, 0, 2047, 1};
    vecs[8]  = '{1'b0, 12'd0,         0,   0, 0, 2047, 1};
    vecs[9]  = '{1'b0, 12'd0,         0,   0, 0, 2047, 1};
    vecs[10] = '{1'b0, 12'd0,         0,   0, 1, 2047, 1};
    vecs[11] = '{1'b0, 12'd0,         64,  0, 1, 2047, 1};
    vecs[12] = '{1'b0, 12'd0,         128, 0, 1, 2047, 1};
    vecs[13] = '{1'b0, 12'd0,         128, 0, 1, 2047, 1};
    vecs[14] = '{1'b1, 12'd0,         64,  0, 1, 2047, 1};
    vecs[15] = '{1'b0, 12'd0,         0,   0, 1, 2047, 1};
    vecs[16] = '{1'b0, 12'd0,         0,   0, 1, 2047, 1};
    vecs[17] = '{1'b1, 12'(-192),     64,  0, 1, 2047, 1};
    vecs[18] = '{1'b0, 12'd0,         128, 0, 1, 2047, 1};

    mainBus.spd = '0;
    mainBus.spd_vld = 1'b0;
    mainBus.en = 1'b0;
    bigBus.spd = '0;
    bigBus.spd_vld = 1'b0;
    bigBus.en = 1'b0;

    // Duty may only move on the edge after a tick, or when en/reset force 0
    fork
      begin : dutyWatch
        logic [PRD_W-1:0] prevDuty;
        logic prevTick;
        logic prevEn;
        logic prevRst;
        prevDuty = '0;
        prevTick = 1'b0;
        prevEn = 1'b0;
        prevRst = 1'b0;
        forever begin
          @(negedge clk);
          if (mainBus.duty != prevDuty) begin
            checks++;
            if (!(prevTick || !prevEn || !mainBus.en || !prevRst || !rst_n)) begin
              failures++;
              $display("[TB] FAIL duty_change_off_boundary actual=%0d->%0d expected=unchanged",
                       prevDuty, mainBus.duty);
            end
          end
          if (mainBus.fwd && mainBus.rev) begin
            checks++;
            failures++;
            $display("[TB] FAIL dir_both_high actual=fwd1_rev1 expected=not_both");
          end
          prevDuty = mainBus.duty;
          prevTick = mainBus.prd_tick;
          prevEn = mainBus.en;
          prevRst = rst_n;
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkMain("reset", 0, 0, 0);
    checkOutput("reset_tick", int'(mainBus.prd_tick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mainBus.en = 1'b1;
    bigBus.en = 1'b1;

    // Big instance: -2048 command, ramp 0 -> 1024 -> 2047 in reverse
    @(posedge clk);
    #1;
    bigBus.spd = 12'(-2048);
    bigBus.spd_vld = 1'b1;
    @(posedge clk);
    #1;
    bigBus.spd_vld = 1'b0;

    // Table: ramp up, reversal with dead time, stop, restart reverse
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].strobe) applyStimulus(vecs[i].spd);
      waitBoundary($sformatf("row%0d", i));
      checkMain($sformatf("row%0d", i), vecs[i].expDuty, vecs[i].expFwd, vecs[i].expRev);
      checkOutput($sformatf("row%0d_bigDuty", i), int'(bigBus.duty), vecs[i].expBigDuty);
      checkOutput($sformatf("row%0d_bigRev", i), int'(bigBus.rev), vecs[i].expBigRev);
      checkOutput($sformatf("row%0d_bigFwd", i), int'(bigBus.fwd), 1 - vecs[i].expBigRev);
    end

    // en drop mid-period at duty 128: forced stop on the next edge
    repeat (100) @(posedge clk);
    @(negedge clk);
    #1;
    mainBus.en = 1'b0;
    @(posedge clk);
    #1;
    checkMain("enDrop", 0, 0, 0);
    @(negedge clk);
    #1;
    mainBus.en = 1'b1;
    waitBoundary("reEnIdleRun");
    checkMain("reEnIdleRun", 0, 0, 1);
    waitBoundary("reEnStep1");
    checkMain("reEnStep1", 64, 0, 1);

    // Strobe in the tick cycle: old target (192) used, new one (64) after
    begin
      int n;
      n = 0;
      while (n < 2100) begin
        @(negedge clk);
        if (mainBus.prd_tick) break;
        n++;
      end
      if (n >= 2100) begin
        checks++;
        failures++;
        $display("[TB] FAIL coincTick_timeout actual=%0d expected=<2100", n);
      end
    end
    #1;
    mainBus.spd = 12'(-64);
    mainBus.spd_vld = 1'b1;
    @(posedge clk);
    #1;
    mainBus.spd_vld = 1'b0;
    checkMain("coincOldTgt", 128, 0, 1);
    waitBoundary("coincNewTgt");
    checkMain("coincNewTgt", 64, 0, 1);

    // Reverse to forward, then reset while in DEAD
    applyStimulus(12'd64);
    waitBoundary("revRampDown");
    checkMain("revRampDown", 0, 0, 1);
    waitBoundary("revDead");
    checkMain("revDead", 0, 0, 0);
    repeat (300) @(posedge clk);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkMain("asyncRst", 0, 0, 0);
    checkOutput("asyncRst_tick", int'(mainBus.prd_tick), 0);
    checkOutput("asyncRst_bigDuty", int'(bigBus.duty), 0);
    checkOutput("asyncRst_bigRev", int'(bigBus.rev), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Period counter restarts at 0: tick after exactly 2047 edges
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!mainBus.prd_tick && n < 2100);
      checkOutput("postRst_tickAlign", n, 2047);
    end

    // Targets were reset too: forward, duty stays 0
    waitBoundary("postRstRun");
    checkMain("postRstRun", 0, 1, 0);
    checkOutput("postRstRun_bigDuty", int'(bigBus.duty), 0);
    checkOutput("postRstRun_bigFwd", int'(bigBus.fwd), 1);
    waitBoundary("postRstHold");
    checkMain("postRstHold", 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
